pcie_us_cfg_mgmt_resp: RTL and testbench

- Responder (completer) model of the UltraScale PCIe core's cfg_mgmt port, the target side of the configuration shim's read/write requests.
- Holds a per-function PCIe Device Control register for PFs and VFs, answers reads and writes with a configurable latency, and drives read_write_done.
- Used in benches and loopback builds in place of the hard IP's configuration management interface.

---
 rtl/pcie_us_cfg_mgmt_resp_if.sv | 25 ++
 rtl/pcie_us_cfg_mgmt_resp.sv | 151 +++++++++++++++
 tb/tb_pcie_us_cfg_mgmt_resp.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pcie_us_cfg_mgmt_resp_if.sv
// cfg_mgmt request/response bundle between a configuration initiator (master)
// and the responder model (slave).
interface pcie_us_cfg_mgmt_resp_if;
  logic [9:0]  cfg_mgmt_addr;
  logic [7:0]  cfg_mgmt_function_number;
  logic        cfg_mgmt_write;
  logic [31:0] cfg_mgmt_write_data;
  logic [3:0]  cfg_mgmt_byte_enable;
  logic        cfg_mgmt_read;
  logic [31:0] cfg_mgmt_read_data;
  logic        cfg_mgmt_read_write_done;
  logic        access_err;

  modport master (
    output cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
           cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read,
    input  cfg_mgmt_read_data, cfg_mgmt_read_write_done, access_err
  );

  modport slave (
    input  cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
           cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read,
    output cfg_mgmt_read_data, cfg_mgmt_read_write_done, access_err
  );
endinterface

// File: rtl/pcie_us_cfg_mgmt_resp.sv
// Completer model of the UltraScale cfg_mgmt port: per-function Device Control
// registers for PFs and VFs, answered after a fixed latency.
module pcie_us_cfg_mgmt_resp #(
  parameter int          PF_COUNT        = 1,
  parameter int          VF_COUNT        = 0,
  parameter int          VF_OFFSET       = 64,
  parameter int          F_COUNT         = PF_COUNT + VF_COUNT,
  parameter logic [11:0] PCIE_CAP_OFFSET = 12'h0C0,
  parameter int          RESP_LATENCY    = 4,
  parameter logic [15:0] DEV_CTRL_RESET  = 16'h2110
) (
  input  logic                   clk,
  input  logic                   rst,
  pcie_us_cfg_mgmt_resp_if.slave cfg,
  output logic [F_COUNT*16-1:0]  dev_ctrl
);

  localparam int          IDX_W         = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
  localparam logic [11:0] DEV_CTRL_BYTE = PCIE_CAP_OFFSET + 12'd8;
  localparam logic [9:0]  DEV_CTRL_ADDR = DEV_CTRL_BYTE[11:2];
  localparam logic [7:0]  LAT_M1        = 8'(RESP_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, TURN} state_t;

  state_t             state_reg, state_next;
  logic [7:0]         cnt_reg, cnt_next;
  logic [9:0]         addr_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               mapped_reg;
  logic               rd_reg;
  logic               wr_reg;
  logic               err_reg;
  logic [1:0]         be_reg;
  logic [15:0]        wdata_reg;
  logic [31:0]        read_data_reg;

  int                 fn_i;
  logic               map_hit;
  logic [IDX_W-1:0]   map_idx;
  logic               accept;
  logic               is_read;
  logic               at_dev_ctrl;
  logic               commit;
  logic [31:0]        rd_live;
  logic [15:0]        dc_arr [F_COUNT];
  logic               unused_bits;

  // Device Status and the upper byte enables have no storage behind them.
  assign unused_bits = ^{cfg.cfg_mgmt_write_data[31:16], cfg.cfg_mgmt_byte_enable[3:2]};

  always_comb begin
    fn_i    = int'(cfg.cfg_mgmt_function_number);
    map_hit = 1'b0;
    map_idx = '0;
    if (fn_i < PF_COUNT) begin
      map_hit = 1'b1;
      map_idx = IDX_W'(fn_i);
    end else if (fn_i >= VF_OFFSET && fn_i < VF_OFFSET + VF_COUNT) begin
      map_hit = 1'b1;
      map_idx = IDX_W'(PF_COUNT + fn_i - VF_OFFSET);
    end
  end

  assign accept = (state_reg == IDLE) && (cfg.cfg_mgmt_read || cfg.cfg_mgmt_write);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (cfg.cfg_mgmt_read || cfg.cfg_mgmt_write) begin
          cnt_next   = LAT_M1;
          state_next = (LAT_M1 == 8'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg == 8'd1) state_next = DONE;
      end
      DONE:    state_next = TURN;
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Request fields are frozen at acceptance so the initiator may change them freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg   <= '0;
      idx_reg    <= '0;
      mapped_reg <= 1'b0;
      rd_reg     <= 1'b0;
      wr_reg     <= 1'b0;
      err_reg    <= 1'b0;
      be_reg     <= '0;
      wdata_reg  <= '0;
    end else if (accept) begin
      addr_reg   <= cfg.cfg_mgmt_addr;
      idx_reg    <= map_idx;
      mapped_reg <= map_hit;
      rd_reg     <= cfg.cfg_mgmt_read;
      wr_reg     <= cfg.cfg_mgmt_write;
      err_reg    <= ~map_hit | (cfg.cfg_mgmt_read & cfg.cfg_mgmt_write);
      be_reg     <= cfg.cfg_mgmt_byte_enable[1:0];
      wdata_reg  <= cfg.cfg_mgmt_write_data[15:0];
    end
  end

  assign is_read     = rd_reg & ~wr_reg;
  assign at_dev_ctrl = mapped_reg && (addr_reg == DEV_CTRL_ADDR);
  assign commit      = (state_reg == DONE) && wr_reg && at_dev_ctrl;
  assign rd_live     = at_dev_ctrl ? {16'h0000, dc_arr[idx_reg]} : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) read_data_reg <= 32'h0;
    else if (state_reg == DONE && is_read) read_data_reg <= rd_live;
  end

  // Live value in the done cycle, held value afterwards until the next read.
  assign cfg.cfg_mgmt_read_data       = (state_reg == DONE && is_read) ? rd_live : read_data_reg;
  assign cfg.cfg_mgmt_read_write_done = (state_reg == DONE);
  assign cfg.access_err               = (state_reg == DONE) && err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < F_COUNT; gi++) begin : g_fn
      logic [15:0] slot_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          slot_reg <= DEV_CTRL_RESET;
        end else if (commit && idx_reg == IDX_W'(gi)) begin
          if (be_reg[0]) slot_reg[7:0]  <= wdata_reg[7:0];
          if (be_reg[1]) slot_reg[15:8] <= wdata_reg[15:8];
        end
      end
      assign dc_arr[gi]            = slot_reg;
      assign dev_ctrl[gi*16 +: 16] = slot_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_resp.sv
// Directed bench: a 2PF+2VF responder at latency 4 and a 1PF responder at latency 1,
// with expected completions queued at issue and checked at done.
module tb_pcie_us_cfg_mgmt_resp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcie_us_cfg_mgmt_resp_if if0 ();
  pcie_us_cfg_mgmt_resp_if if1 ();
  logic [63:0] dc0;
  logic [15:0] dc1;

  pcie_us_cfg_mgmt_resp #(.PF_COUNT(2), .VF_COUNT(2), .VF_OFFSET(64), .RESP_LATENCY(4))
    dut0 (.clk(clk), .rst(rst), .cfg(if0), .dev_ctrl(dc0));
  pcie_us_cfg_mgmt_resp #(.PF_COUNT(1), .VF_COUNT(0), .RESP_LATENCY(1))
    dut1 (.clk(clk), .rst(rst), .cfg(if1), .dev_ctrl(dc1));

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          chk_data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   sel = 1'b0;

  logic        done_s, err_s;
  logic [31:0] rdata_s;
  assign done_s  = sel ? if1.cfg_mgmt_read_write_done : if0.cfg_mgmt_read_write_done;
  assign err_s   = sel ? if1.access_err : if0.access_err;
  assign rdata_s = sel ? if1.cfg_mgmt_read_data : if0.cfg_mgmt_read_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s, input bit rd, input bit wr, input logic [9:0] a,
                       input logic [7:0] fn, input logic [31:0] d, input logic [3:0] be);
    if (s) begin
      if1.cfg_mgmt_read = rd; if1.cfg_mgmt_write = wr; if1.cfg_mgmt_addr = a;
      if1.cfg_mgmt_function_number = fn; if1.cfg_mgmt_write_data = d; if1.cfg_mgmt_byte_enable = be;
    end else begin
      if0.cfg_mgmt_read = rd; if0.cfg_mgmt_write = wr; if0.cfg_mgmt_addr = a;
      if0.cfg_mgmt_function_number = fn; if0.cfg_mgmt_write_data = d; if0.cfg_mgmt_byte_enable = be;
    end
  endtask

  // Called at a negedge with the addressed responder idle.
  task automatic issue(input bit s, input bit rd, input bit wr, input logic [9:0] a,
                       input logic [7:0] fn, input logic [31:0] d, input logic [3:0] be,
                       input bit chk, input logic [31:0] xd, input logic xe, input int hold);
    exp_t e;
    int   n;
    bit   seen;
    sel = s;
    e.data = xd; e.err = xe; e.chk_data = chk; e.lat = s ? 1 : 4;
    sb.push_back(e);
    drive(s, rd, wr, a, fn, d, be);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (done_s === 1'b1) seen = 1'b1;
    end
    e = sb.pop_front();
    check("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("latency", 64'(n), 64'(e.lat));
      if (e.chk_data) check("read_data", 64'(rdata_s), 64'(e.data));
      check("access_err", 64'(err_s), 64'(e.err));
    end
    $display("txn dut=%0d rd=%0b wr=%0b addr=%h fn=%0d be=%b lat=%0d data=%h err=%0b",
             s, rd, wr, a, fn, be, n, rdata_s, err_s);
    repeat (hold) @(negedge clk);
    drive(s, 1'b0, 1'b0, 10'h0, 8'h0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_extra_done", 64'(done_s), 64'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int extra;
    drive(1'b0, 1'b0, 1'b0, 10'h0, 8'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 10'h0, 8'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    check("rst_done", 64'(if0.cfg_mgmt_read_write_done), 64'd0);
    check("rst_err", 64'(if0.access_err), 64'd0);
    check("rst_rdata", 64'(if0.cfg_mgmt_read_data), 64'd0);
    check("rst_dev_ctrl", dc0, 64'h2110_2110_2110_2110);
    rst = 1'b0;
    @(negedge clk);

    // PF0 read / masked writes at latency 4
    issue(0, 1, 0, 10'h032, 8'd0, 32'h0, 4'h0, 1, 32'h0000_2110, 0, 0);
    issue(0, 0, 1, 10'h032, 8'd0, 32'hFFFF_50A0, 4'b0001, 0, 32'h0, 0, 0);
    check("dc_be0001", 64'(dc0[15:0]), 64'h21A0);
    check("rdata_held_after_write", 64'(if0.cfg_mgmt_read_data), 64'h0000_2110);
    issue(0, 1, 0, 10'h032, 8'd0, 32'h0, 4'h0, 1, 32'h0000_21A0, 0, 0);
    issue(0, 0, 1, 10'h032, 8'd0, 32'hFFFF_50A0, 4'b1110, 0, 32'h0, 0, 0);
    check("dc_be1110", 64'(dc0[15:0]), 64'h50A0);
    issue(0, 1, 0, 10'h032, 8'd0, 32'h0, 4'h0, 1, 32'h0000_50A0, 0, 0);

    // VF mapping and unmapped functions
    do_reset();
    issue(0, 0, 1, 10'h032, 8'd65, 32'h0000_0020, 4'b0011, 0, 32'h0, 0, 0);
    check("dc_vf1", dc0, 64'h0020_2110_2110_2110);
    issue(0, 1, 0, 10'h032, 8'd65, 32'h0, 4'h0, 1, 32'h0000_0020, 0, 0);
    issue(0, 1, 0, 10'h032, 8'd64, 32'h0, 4'h0, 1, 32'h0000_2110, 0, 0);
    issue(0, 1, 0, 10'h032, 8'd3,  32'h0, 4'h0, 1, 32'h0, 1, 0);
    issue(0, 1, 0, 10'h032, 8'd66, 32'h0, 4'h0, 1, 32'h0, 1, 0);
    issue(0, 0, 1, 10'h032, 8'd66, 32'h0000_FFFF, 4'b0011, 0, 32'h0, 1, 0);
    check("dc_unmapped_write", dc0, 64'h0020_2110_2110_2110);
    issue(0, 1, 0, 10'h000, 8'd0,  32'h0, 4'h0, 1, 32'h0, 0, 0);

    // Simultaneous read+write is a write with access_err
    issue(0, 1, 1, 10'h032, 8'd0, 32'h0000_0040, 4'b0011, 1, 32'h0, 1, 0);
    check("dc_rdwr", 64'(dc0[15:0]), 64'h0040);
    // Read held through DONE and TURN completes once
    issue(0, 1, 0, 10'h032, 8'd0, 32'h0, 4'h0, 1, 32'h0000_0040, 0, 1);

    // Reset while a write waits
    sel = 1'b0;
    drive(0, 1'b0, 1'b1, 10'h032, 8'd0, 32'h0000_1234, 4'b0011);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 10'h0, 8'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if0.cfg_mgmt_read_write_done === 1'b1) extra++;
    end
    check("rst_mid_no_done", 64'(extra), 64'd0);
    check("rst_mid_dev_ctrl", dc0, 64'h2110_2110_2110_2110);
    issue(0, 1, 0, 10'h032, 8'd0, 32'h0, 4'h0, 1, 32'h0000_2110, 0, 0);

    // Latency-1 responder
    issue(1, 1, 0, 10'h032, 8'd0, 32'h0, 4'h0, 1, 32'h0000_2110, 0, 0);
    issue(1, 0, 1, 10'h032, 8'd0, 32'hABCD_1234, 4'b0011, 0, 32'h0, 0, 0);
    check("dc1_write", 64'(dc1), 64'h1234);
    issue(1, 1, 0, 10'h032, 8'd0, 32'h0, 4'h0, 1, 32'h0000_1234, 0, 0);
    issue(1, 1, 0, 10'h032, 8'd1, 32'h0, 4'h0, 1, 32'h0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
